// File: rtl/npn_pkg.sv
// npn_pkg: shared types and helpers for the NPN-transform evaluation pipe.
//   npn_state_e    : sequencer states (IDLE, SWEEP, DRAIN)
//   calc_pw        : width of one permutation field, max(1, clog2(n_in))
//   calc_tt_w      : truth-table width, 2**n_in
//   identity_perm  : packed permutation with field i = i
//   perm_is_valid  : 1 when every field is in range and no field repeats
// Permutations are handled packed in a PERM_MAX_W-bit vector, which holds
// the largest legal case (6 fields of 3 bits).
package npn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } npn_state_e;

    localparam int PERM_MAX_W = 18;

    function automatic int calc_pw(input int n_in);
        int w;
        w = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < n_in) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int calc_tt_w(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic logic [PERM_MAX_W-1:0] identity_perm(input int n_in, input int pw);
        logic [PERM_MAX_W-1:0] p;
        p = {PERM_MAX_W{1'b0}};
        for (int i = 0; i < 6; i++) begin
            if (i < n_in) begin
                p = p | (PERM_MAX_W'(i) << (i * pw));
            end
        end
        return p;
    endfunction

    function automatic logic perm_is_valid(input logic [PERM_MAX_W-1:0] perm,
                                           input int n_in, input int pw);
        logic [7:0]            seen;
        logic [PERM_MAX_W-1:0] mask;
        logic [PERM_MAX_W-1:0] field;
        logic                  ok;
        seen = 8'd0;
        ok   = 1'b1;
        mask = PERM_MAX_W'((1 << pw) - 1);
        for (int i = 0; i < 6; i++) begin
            if (i < n_in) begin
                field = (perm >> (i * pw)) & mask;
                if (field >= PERM_MAX_W'(n_in)) begin
                    ok = 1'b0;
                end else if (seen[field[2:0]]) begin
                    ok = 1'b0;
                end else begin
                    seen[field[2:0]] = 1'b1;
                end
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/npn_xform.sv
// npn_xform: combinational input negation and permutation.
//   x      : raw input vector
//   neg_in : per-input negation mask
//   perm   : packed fields, field i selects the source input for index bit i
//   idx    : resulting truth-table index
module npn_xform
    import npn_pkg::*;
#(
    parameter  int N_IN = 4,
    localparam int PW   = calc_pw(N_IN)
) (
    input  logic [N_IN-1:0]    x,
    input  logic [N_IN-1:0]    neg_in,
    input  logic [N_IN*PW-1:0] perm,
    output logic [N_IN-1:0]    idx
);

    logic [N_IN-1:0] z_s;

    // Negate, then gather each index bit from its selected source input.
    always_comb begin
        z_s = x ^ neg_in;
        idx = {N_IN{1'b0}};
        for (int i = 0; i < N_IN; i++) begin
            idx[i] = z_s[perm[i*PW +: PW]];
        end
    end

endmodule

// File: rtl/npn_eval_pipe.sv
// npn_eval_pipe: evaluates an NPN-transformed Boolean function on a
// valid/ready stream, and can sweep all input vectors to produce the
// transformed truth table.
//   clk, rst                 : clock, asynchronous active-high reset
//   cfg_we/cfg_ready         : configuration write handshake
//   cfg_tt/neg_in/perm/neg_out: base table and NPN transform
//   cfg_err                  : one-cycle pulse after a rejected write
//   in_valid/in_ready/in_x   : input vector stream
//   out_valid/out_ready/out_y: result stream
//   sweep_start/busy/done/tt : exhaustive sweep control and result table
module npn_eval_pipe
    import npn_pkg::*;
#(
    parameter  int                     N_IN    = 4,
    parameter  logic [(1<<N_IN)-1:0]   TT_INIT = 16'h7906,
    localparam int                     TT_W    = calc_tt_w(N_IN),
    localparam int                     PW      = calc_pw(N_IN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    output logic                 cfg_ready,
    input  logic [TT_W-1:0]      cfg_tt,
    input  logic [N_IN-1:0]      cfg_neg_in,
    input  logic [N_IN*PW-1:0]   cfg_perm,
    input  logic                 cfg_neg_out,
    output logic                 cfg_err,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN-1:0]      in_x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_y,
    input  logic                 sweep_start,
    output logic                 sweep_busy,
    output logic                 sweep_done,
    output logic [TT_W-1:0]      sweep_tt
);

    localparam logic [PERM_MAX_W-1:0] PERM_ID_FULL = identity_perm(N_IN, PW);
    localparam logic [N_IN*PW-1:0]    PERM_ID      = PERM_ID_FULL[N_IN*PW-1:0];
    localparam logic [N_IN-1:0]       CNT_LAST     = {N_IN{1'b1}};
    localparam logic [N_IN-1:0]       CNT_ONE      = {{(N_IN-1){1'b0}}, 1'b1};

    // Configuration registers
    logic [TT_W-1:0]    tt_r;
    logic [N_IN-1:0]    neg_in_r;
    logic [N_IN*PW-1:0] perm_r;
    logic               neg_out_r;
    logic               cfg_err_r;

    // Sequencer
    npn_state_e         state_r;
    logic [N_IN-1:0]    cnt_r;
    logic               sweep_done_r;
    logic [TT_W-1:0]    sweep_tt_r;

    // Pipeline stages; s1_sweep_r tags sweep vectors, s1_vec_r keeps the
    // untransformed vector so the sweep result lands at its own position.
    logic               s1_valid_r;
    logic               s1_sweep_r;
    logic [N_IN-1:0]    s1_idx_r;
    logic [N_IN-1:0]    s1_vec_r;
    logic               s2_valid_r;
    logic               s2_y_r;

    // Combinational control
    logic               cfg_ready_s;
    logic               cfg_accept_s;
    logic               perm_ok_s;
    logic               s2_load_s;
    logic               s1_load_s;
    logic               in_ready_s;
    logic               sweep_go_s;
    logic               inj_valid_s;
    logic               inj_sweep_s;
    logic [N_IN-1:0]    x_sel_s;
    logic [N_IN-1:0]    idx_s;
    logic               y_s;

    // Handshake decisions, stage-1 source select and table lookup.
    always_comb begin
        cfg_ready_s  = (state_r == ST_IDLE) && !s1_valid_r && !s2_valid_r;
        cfg_accept_s = cfg_we && cfg_ready_s;
        perm_ok_s    = perm_is_valid(PERM_MAX_W'(cfg_perm), N_IN, PW);
        s2_load_s    = !s2_valid_r || out_ready;
        // A sweep vector never waits on stage 2: its result goes to sweep_tt.
        s1_load_s    = !s1_valid_r || s2_load_s || s1_sweep_r;
        in_ready_s   = s1_load_s && (state_r == ST_IDLE);
        // Config wins over a sweep start; so does a stream vector accepted in
        // the same cycle, otherwise its result would surface mid-sweep.
        sweep_go_s   = sweep_start && cfg_ready_s && !cfg_accept_s && !in_valid;
        if (state_r == ST_SWEEP) begin
            x_sel_s     = cnt_r;
            inj_valid_s = 1'b1;
            inj_sweep_s = 1'b1;
        end else begin
            x_sel_s     = in_x;
            inj_valid_s = in_valid && in_ready_s;
            inj_sweep_s = 1'b0;
        end
        y_s = tt_r[s1_idx_r] ^ neg_out_r;
    end

    npn_xform #(
        .N_IN (N_IN)
    ) u_xform (
        .x      (x_sel_s),
        .neg_in (neg_in_r),
        .perm   (perm_r),
        .idx    (idx_s)
    );

    // Configuration write: all-or-nothing, invalid permutations flag cfg_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_r      <= TT_INIT;
            neg_in_r  <= {N_IN{1'b0}};
            perm_r    <= PERM_ID;
            neg_out_r <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= cfg_accept_s && !perm_ok_s;
            if (cfg_accept_s && perm_ok_s) begin
                tt_r      <= cfg_tt;
                neg_in_r  <= cfg_neg_in;
                perm_r    <= cfg_perm;
                neg_out_r <= cfg_neg_out;
            end
        end
    end

    // Two-stage valid/ready pipeline: stage 1 holds idx, stage 2 holds y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_sweep_r <= 1'b0;
            s1_idx_r   <= {N_IN{1'b0}};
            s1_vec_r   <= {N_IN{1'b0}};
            s2_valid_r <= 1'b0;
            s2_y_r     <= 1'b0;
        end else begin
            if (s1_load_s) begin
                s1_valid_r <= inj_valid_s;
                s1_sweep_r <= inj_sweep_s;
                s1_idx_r   <= idx_s;
                s1_vec_r   <= x_sel_s;
            end
            if (s2_load_s) begin
                s2_valid_r <= s1_valid_r && !s1_sweep_r;
                if (s1_valid_r && !s1_sweep_r) begin
                    s2_y_r <= y_s;
                end
            end
        end
    end

    // Sweep sequencer; sweep_tt acts as stage 2 for sweep vectors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {N_IN{1'b0}};
            sweep_done_r <= 1'b0;
            sweep_tt_r   <= {TT_W{1'b0}};
        end else begin
            sweep_done_r <= 1'b0;
            if (s1_valid_r && s1_sweep_r) begin
                sweep_tt_r[s1_vec_r] <= y_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (sweep_go_s) begin
                        state_r <= ST_SWEEP;
                        cnt_r   <= {N_IN{1'b0}};
                    end
                end
                ST_SWEEP: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Only the last sweep vector remains in stage 1 here.
                    if (s1_valid_r && s1_sweep_r) begin
                        state_r      <= ST_IDLE;
                        sweep_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready  = cfg_ready_s;
    assign cfg_err    = cfg_err_r;
    assign in_ready   = in_ready_s;
    assign out_valid  = s2_valid_r;
    assign out_y      = s2_y_r;
    assign sweep_busy = (state_r != ST_IDLE);
    assign sweep_done = sweep_done_r;
    assign sweep_tt   = sweep_tt_r;

endmodule

// File: tb/tb_npn_eval_pipe.sv
module tb_npn_eval_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic        cfg_ready;
    logic [15:0] cfg_tt;
    logic [3:0]  cfg_neg_in;
    logic [7:0]  cfg_perm;
    logic        cfg_neg_out;
    logic        cfg_err;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_x;
    logic        out_valid;
    logic        out_ready;
    logic        out_y;
    logic        sweep_start;
    logic        sweep_busy;
    logic        sweep_done;
    logic [15:0] sweep_tt;

    npn_eval_pipe #(.N_IN(4), .TT_INIT(16'h7906)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_tt(cfg_tt),
        .cfg_neg_in(cfg_neg_in), .cfg_perm(cfg_perm), .cfg_neg_out(cfg_neg_out),
        .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy),
        .sweep_done(sweep_done), .sweep_tt(sweep_tt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (what the DUT's configuration should be)
    logic [15:0] m_tt;
    logic [3:0]  m_neg_in;
    int          m_perm[4];
    logic        m_neg_out;

    logic        exp_q[$];
    int          rx_cnt = 0;
    logic [63:0] rx_word = 64'd0;

    int P_ID[4];
    int P_BAD[4];
    int P_REV[4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // f'(x): negate inputs, gather index bit i from input p[i], look up, negate output
    function automatic logic model_y(input logic [15:0] tt, input logic [3:0] ni,
                                     input int p[4], input logic no, input int x);
        int z;
        int idx;
        z = x ^ int'(ni);
        idx = 0;
        for (int i = 0; i < 4; i++) idx += ((z >> p[i]) & 1) << i;
        return tt[idx] ^ no;
    endfunction

    function automatic logic [15:0] model_tt(input logic [15:0] tt, input logic [3:0] ni,
                                             input int p[4], input logic no);
        logic [15:0] r;
        r = 16'd0;
        for (int k = 0; k < 16; k++) r[k] = model_y(tt, ni, p, no, k);
        return r;
    endfunction

    function automatic logic model_perm_ok(input int p[4]);
        int cnt[4];
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int i = 0; i < 4; i++) begin
            if (p[i] < 0 || p[i] > 3) return 1'b0;
            cnt[p[i]]++;
        end
        for (int i = 0; i < 4; i++) if (cnt[i] != 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [7:0] pack_perm(input int p[4]);
        logic [7:0] r;
        r = 8'd0;
        for (int i = 0; i < 4; i++) r = r | (8'(p[i] & 3) << (2 * i));
        return r;
    endfunction

    // Compare process: stream results against the scoreboard, sweeps silent
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)
                exp_q.push_back(model_y(m_tt, m_neg_in, m_perm, m_neg_out, int'(in_x)));
            if (sweep_busy) check("out_valid quiet in sweep", 32'(out_valid), 32'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected out_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("out_y vs model", 32'(out_y), 32'(exp_q[0]));
                    if (out_ready) begin
                        rx_word[rx_cnt] = out_y;
                        rx_cnt++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic wait_cfg_ready(input string nm);
        int guard;
        guard = 0;
        while (!cfg_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check({nm, " idle wait"}, 32'(cfg_ready), 32'd1);
    endtask

    task automatic cfg_write(input logic [15:0] tt, input logic [3:0] ni, input int p[4],
                             input logic no, input string nm);
        logic ok;
        wait_cfg_ready(nm);
        ok = model_perm_ok(p);
        cfg_we = 1'b1; cfg_tt = tt; cfg_neg_in = ni; cfg_perm = pack_perm(p); cfg_neg_out = no;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (ok) begin
            m_tt = tt; m_neg_in = ni; m_perm = p; m_neg_out = no;
        end
        check({nm, " cfg_err pulse"}, 32'(cfg_err), 32'(!ok));
        @(posedge clk); #1;
        check({nm, " cfg_err clear"}, 32'(cfg_err), 32'd0);
    endtask

    task automatic run_sweep(input logic [15:0] exp_tt, input string nm);
        int   edges;
        logic seen;
        wait_cfg_ready(nm);
        sweep_start = 1'b1;
        @(posedge clk); #1;
        sweep_start = 1'b0;
        check({nm, " busy"}, 32'(sweep_busy), 32'd1);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk); edges++; #1;
            if (sweep_done) seen = 1'b1;
        end
        check({nm, " done latency"}, 32'(edges), 32'd17);
        check({nm, " sweep_tt"}, 32'(sweep_tt), 32'(exp_tt));
        @(posedge clk); #1;
        check({nm, " done one-shot"}, 32'(sweep_done), 32'd0);
        check({nm, " busy clear"}, 32'(sweep_busy), 32'd0);
    endtask

    task automatic run_stream(input int n, input logic stall, input string nm);
        int   i;
        int   c;
        int   start_rx;
        logic acc;
        i = 0; c = 0; start_rx = rx_cnt;
        while ((rx_cnt - start_rx) < n && c < 200) begin
            in_valid  = (i < n);
            in_x      = 4'(i);
            out_ready = !(stall && c >= 3 && c <= 5);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (stall && c >= 3 && c <= 5) check({nm, " in_ready stalled"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            if (acc) i++;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({nm, " result count"}, 32'(rx_cnt - start_rx), 32'(n));
        check({nm, " queue empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " out_valid"}, 32'(out_valid), 32'd0);
        check({nm, " out_y"}, 32'(out_y), 32'd0);
        check({nm, " cfg_err"}, 32'(cfg_err), 32'd0);
        check({nm, " sweep_busy"}, 32'(sweep_busy), 32'd0);
        check({nm, " sweep_done"}, 32'(sweep_done), 32'd0);
        check({nm, " sweep_tt"}, 32'(sweep_tt), 32'd0);
    endtask

    task automatic model_reset();
        m_tt = 16'h7906; m_neg_in = 4'd0; m_perm = P_ID; m_neg_out = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   seen_done;
        logic [15:0] exp_rev;
        P_ID  = '{0, 1, 2, 3};
        P_BAD = '{0, 0, 2, 3};
        P_REV = '{3, 2, 1, 0};
        model_reset();
        rst = 1'b1; cfg_we = 1'b0; cfg_tt = 16'd0; cfg_neg_in = 4'd0; cfg_perm = 8'd0;
        cfg_neg_out = 1'b0; in_valid = 1'b0; in_x = 4'd0; out_ready = 1'b1; sweep_start = 1'b0;

        // Hand-computed pins on the model itself
        check("model identity", 32'(model_tt(16'h7906, 4'd0, P_ID, 1'b0)), 32'h7906);
        check("model neg_out", 32'(model_tt(16'h7906, 4'd0, P_ID, 1'b1)), 32'h86F9);
        check("model bad perm", 32'(model_perm_ok(P_BAD)), 32'd0);
        check("model rev x0", 32'(model_y(16'h7906, 4'b0101, P_REV, 1'b0, 0)), 32'd0);
        check("model rev x1", 32'(model_y(16'h7906, 4'b0101, P_REV, 1'b0, 1)), 32'd1);

        #2;
        check_reset_outputs("in reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post-reset cfg_ready", 32'(cfg_ready), 32'd1);
        check("post-reset in_ready", 32'(in_ready), 32'd1);
        check_reset_outputs("post-reset");

        run_sweep(16'h7906, "sweep reset cfg");

        cfg_write(16'hFFFF, 4'b1111, P_BAD, 1'b1, "bad perm");
        run_sweep(16'h7906, "sweep after bad perm");

        run_stream(16, 1'b1, "stream stall");
        check("stream word", 32'(rx_word[15:0]), 32'h7906);

        cfg_write(16'h7906, 4'd0, P_ID, 1'b1, "neg_out");
        run_sweep(16'h86F9, "sweep neg_out");

        cfg_write(16'h7906, 4'b0101, P_REV, 1'b0, "rev cfg");
        exp_rev = model_tt(16'h7906, 4'b0101, P_REV, 1'b0);
        run_sweep(exp_rev, "sweep rev");
        run_stream(8, 1'b0, "stream rev");

        // Reset five edges into a sweep
        wait_cfg_ready("abort");
        sweep_start = 1'b1;
        @(posedge clk); #1;
        sweep_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("abort in reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort cfg_ready", 32'(cfg_ready), 32'd1);
        check("abort in_ready", 32'(in_ready), 32'd1);
        seen_done = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (sweep_done) seen_done++;
        end
        check("abort no sweep_done", 32'(seen_done), 32'd0);
        check_reset_outputs("abort settled");
        run_sweep(16'h7906, "sweep after abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
